// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, instruction-field and FSM-state definitions for the ALU and its control stage.
package alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_OR   = 4'd2,
      OP_AND  = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOT  = 4'd5,
      OP_LD   = 4'd6,
      OP_ST   = 4'd7,
      OP_CLC  = 4'd8,
      OP_HALT = 4'd9,
      OP_NOP  = 4'd15
   } op_t;
   typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;
   localparam int OP_LO   = 12;
   localparam int IMM_BIT = 11;
   localparam int IDX_LO  = 8;
   localparam int IMM_LO  = 0;
endpackage

// File: rtl/alu_acc_regfile.sv
// alu_acc_regfile: NREG x 8 general registers, one synchronous write port, one asynchronous read port.
module alu_acc_regfile #(
   parameter int NREG = 8,
   localparam int IDX_W = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [7:0]       rdata
);
   logic [7:0] mem [NREG];
   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < NREG; i++) mem[i] <= '0;
      else if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: instruction handshake, accumulator/carry/register state and ALU drive for the external 8-bit ALU.
// Defining ALU_ACC_ZERO_FLAG_EN adds the OUT_Z zero flag, updated on ALU-op commits only.
module alu_acc_ctrl
   import alu_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] IN_INSTR,
   input  logic        IN_VALID,
   output logic        OUT_READY,
   output logic [7:0]  OUT_ALU_A,
   output logic [7:0]  OUT_ALU_R,
   output logic [3:0]  OUT_ALU_OP,
   output logic        OUT_ALU_CY,
   input  logic [7:0]  IN_ALU_A,
   input  logic        IN_ALU_CY,
   output logic [7:0]  OUT_ACC,
   output logic        OUT_CY,
   output logic        OUT_DONE,
   output logic        OUT_HALT,
   output logic        OUT_ERR
`ifdef ALU_ACC_ZERO_FLAG_EN
   ,
   output logic        OUT_Z
`endif
);
   localparam int IDX_W = $clog2(NREG);
   state_t state, next;
   logic [15:0] ir;
   logic [7:0] acc, rdata;
   logic cy, done, err;
   logic [3:0] op;
   logic [IDX_W-1:0] idx;
   logic exec, alu_op, illegal;
   assign op      = ir[OP_LO +: 4];
   assign idx     = ir[IDX_LO +: IDX_W];
   assign exec    = state == EXEC;
   assign alu_op  = op <= OP_LD;
   assign illegal = op > OP_HALT && op != OP_NOP;
   always_comb begin
      next = state;
      next = (state == IDLE && IN_VALID) ? EXEC :
             (state == EXEC) ? (op == OP_HALT ? HALT : IDLE) : state;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         ir    <= '0;
         acc   <= '0;
         cy    <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= next;
         done  <= exec;
         if (state == IDLE && IN_VALID) ir <= IN_INSTR;
         if (exec && alu_op) begin
            acc <= IN_ALU_A;
            cy  <= IN_ALU_CY;
         end
         if (exec && op == OP_CLC) cy <= 1'b0;
         if (exec && illegal) err <= 1'b1;
      end
   end
`ifdef ALU_ACC_ZERO_FLAG_EN
   logic z;
   always_ff @(posedge CLK)
      if (RST) z <= 1'b0;
      else if (exec && alu_op) z <= IN_ALU_A == 8'h00;
   assign OUT_Z = z;
`endif
   alu_acc_regfile #(.NREG(NREG)) u_rf (
      .clk   (CLK),
      .rst   (RST),
      .we    (exec && op == OP_ST),
      .waddr (idx),
      .wdata (acc),
      .raddr (idx),
      .rdata (rdata)
   );
   assign OUT_READY  = state == IDLE;
   assign OUT_HALT   = state == HALT;
   assign OUT_ALU_A  = acc;
   assign OUT_ALU_R  = ir[IMM_BIT] ? ir[IMM_LO +: 8] : rdata;
   assign OUT_ALU_OP = alu_op ? op : OP_LD;
   assign OUT_ALU_CY = cy;
   assign OUT_ACC    = acc;
   assign OUT_CY     = cy;
   assign OUT_DONE   = done;
   assign OUT_ERR    = err;
endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: self-checking bench with a behavioural ALU beside the DUT and an arithmetic reference model.
module tb_alu_acc_ctrl;
   logic CLK = 0, RST = 1, IN_VALID = 0;
   logic [15:0] IN_INSTR = '0;
   logic OUT_READY, OUT_ALU_CY, IN_ALU_CY, OUT_CY, OUT_DONE, OUT_HALT, OUT_ERR;
   logic [7:0] OUT_ALU_A, OUT_ALU_R, IN_ALU_A, OUT_ACC;
   logic [3:0] OUT_ALU_OP;
`ifdef ALU_ACC_ZERO_FLAG_EN
   logic OUT_Z;
`endif
   int n_ok = 0, n_chk = 0;
   int m_acc, m_cy, m_err, m_z;
   int m_r [8];
   logic mid_done, mid_ready;
   logic [3:0] mid_op;
   logic [7:0] mid_r;

   always #5 CLK = ~CLK;

   alu_acc_ctrl dut (
      .CLK(CLK), .RST(RST), .IN_INSTR(IN_INSTR), .IN_VALID(IN_VALID), .OUT_READY(OUT_READY),
      .OUT_ALU_A(OUT_ALU_A), .OUT_ALU_R(OUT_ALU_R), .OUT_ALU_OP(OUT_ALU_OP), .OUT_ALU_CY(OUT_ALU_CY),
      .IN_ALU_A(IN_ALU_A), .IN_ALU_CY(IN_ALU_CY), .OUT_ACC(OUT_ACC), .OUT_CY(OUT_CY),
      .OUT_DONE(OUT_DONE), .OUT_HALT(OUT_HALT), .OUT_ERR(OUT_ERR)
`ifdef ALU_ACC_ZERO_FLAG_EN
      , .OUT_Z(OUT_Z)
`endif
   );

   // Stand-in for the neighbouring ALU: add/sub with carry/borrow in, logic ops clear carry.
   always_comb begin
      IN_ALU_A  = OUT_ALU_R;
      IN_ALU_CY = 1'b0;
      case (OUT_ALU_OP)
         4'd0: {IN_ALU_CY, IN_ALU_A} = {1'b0, OUT_ALU_A} + {1'b0, OUT_ALU_R} + {8'd0, OUT_ALU_CY};
         4'd1: {IN_ALU_CY, IN_ALU_A} = {1'b0, OUT_ALU_A} - {1'b0, OUT_ALU_R} - {8'd0, OUT_ALU_CY};
         4'd2: IN_ALU_A = OUT_ALU_A | OUT_ALU_R;
         4'd3: IN_ALU_A = OUT_ALU_A & OUT_ALU_R;
         4'd4: IN_ALU_A = OUT_ALU_A ^ OUT_ALU_R;
         4'd5: IN_ALU_A = ~OUT_ALU_A;
         default: IN_ALU_A = OUT_ALU_R;
      endcase
   end

   function automatic void model_reset();
      m_acc = 0; m_cy = 0; m_err = 0; m_z = 0;
      foreach (m_r[i]) m_r[i] = 0;
   endfunction

   function automatic int operand(input logic [15:0] ins);
      return ins[11] ? int'(ins[7:0]) : m_r[ins[10:8]];
   endfunction

   function automatic void model_step(input logic [15:0] ins);
      int op = int'(ins[15:12]);
      int r = operand(ins);
      int s;
      if (op <= 6) begin
         case (op)
            0: s = m_acc + r + m_cy;
            1: s = m_acc - r - m_cy;
            2: s = m_acc | r;
            3: s = m_acc & r;
            4: s = m_acc ^ r;
            5: s = 255 - m_acc;
            default: s = r;
         endcase
         m_cy  = (op == 0 && s > 255) || (op == 1 && s < 0) ? 1 : 0;
         m_acc = s & 255;
         m_z   = m_acc == 0 ? 1 : 0;
      end else if (op == 7) m_r[ins[10:8]] = m_acc;
      else if (op == 8) m_cy = 0;
      else if (op >= 10 && op <= 14) m_err = 1;
   endfunction

   task automatic do_reset();
      RST = 1; IN_VALID = 0;
      repeat (2) @(posedge CLK);
      #1 RST = 0;
      model_reset();
   endtask

   task automatic exec_instr(input logic [15:0] ins);
      IN_VALID = 1; IN_INSTR = ins;
      @(posedge CLK); #1;
      IN_VALID = 0; IN_INSTR = 16'($urandom);
      mid_done = OUT_DONE; mid_ready = OUT_READY; mid_op = OUT_ALU_OP; mid_r = OUT_ALU_R;
      @(posedge CLK); #1;
      model_step(ins);
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (OUT_READY !== 1'b1) $display("FAIL rst_ready got %b exp 1", OUT_READY); else n_ok++;
      n_chk++; if ({OUT_DONE, OUT_HALT, OUT_ERR} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {OUT_DONE, OUT_HALT, OUT_ERR}); else n_ok++;
      n_chk++; if ({OUT_ACC, OUT_CY} !== 9'h0) $display("FAIL rst_acc_cy got %h exp 0", {OUT_ACC, OUT_CY}); else n_ok++;
      n_chk++; if ({OUT_ALU_A, OUT_ALU_R, OUT_ALU_OP, OUT_ALU_CY} !== 21'h0) $display("FAIL rst_alu got %h exp 0", {OUT_ALU_A, OUT_ALU_R, OUT_ALU_OP, OUT_ALU_CY}); else n_ok++;
`ifdef ALU_ACC_ZERO_FLAG_EN
      n_chk++; if (OUT_Z !== 1'b0) $display("FAIL rst_z got %b exp 0", OUT_Z); else n_ok++;
`endif
   endtask

   task automatic test_ld();
      exec_instr(16'h683C);
      n_chk++; if ({mid_done, mid_ready} !== 2'b00) $display("FAIL ld_mid got %b exp 00", {mid_done, mid_ready}); else n_ok++;
      n_chk++; if ({OUT_DONE, OUT_READY} !== 2'b11) $display("FAIL ld_done got %b exp 11", {OUT_DONE, OUT_READY}); else n_ok++;
      n_chk++; if (OUT_ACC !== 8'h3C || OUT_CY !== 1'b0) $display("FAIL ld_acc got %h/%b exp 3c/0", OUT_ACC, OUT_CY); else n_ok++;
      @(posedge CLK); #1;
      n_chk++; if (OUT_DONE !== 1'b0) $display("FAIL ld_pulse got %b exp 0", OUT_DONE); else n_ok++;
   endtask

   task automatic test_add_carry();
      exec_instr(16'h68F0);
      exec_instr(16'h0820);
      n_chk++; if (OUT_ACC !== 8'h10 || OUT_CY !== 1'b1) $display("FAIL add_cout got %h/%b exp 10/1", OUT_ACC, OUT_CY); else n_ok++;
      exec_instr(16'h0800);
      n_chk++; if (OUT_ACC !== 8'h11 || OUT_CY !== 1'b0) $display("FAIL add_cin got %h/%b exp 11/0", OUT_ACC, OUT_CY); else n_ok++;
   endtask

   task automatic test_st_or();
      exec_instr(16'h6805);
      exec_instr(16'h7300);
      exec_instr(16'h6800);
      exec_instr(16'h2300);
      n_chk++; if (mid_r !== 8'h05 || mid_op !== 4'd2) $display("FAIL or_drive got %h/%h exp 05/2", mid_r, mid_op); else n_ok++;
      n_chk++; if (OUT_ACC !== 8'h05 || OUT_CY !== 1'b0) $display("FAIL or_reg got %h/%b exp 05/0", OUT_ACC, OUT_CY); else n_ok++;
   endtask

   task automatic test_illegal();
      exec_instr(16'h6877);
      exec_instr(16'hC8AA);
      n_chk++; if (OUT_ACC !== 8'h77 || OUT_ERR !== 1'b1) $display("FAIL ill_acc_err got %h/%b exp 77/1", OUT_ACC, OUT_ERR); else n_ok++;
      exec_instr(16'h0801);
      n_chk++; if (OUT_ACC !== 8'h78 || OUT_ERR !== 1'b1) $display("FAIL ill_sticky got %h/%b exp 78/1", OUT_ACC, OUT_ERR); else n_ok++;
      do_reset();
      n_chk++; if (OUT_ERR !== 1'b0) $display("FAIL ill_clear got %b exp 0", OUT_ERR); else n_ok++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [15:0] ins = 16'($urandom);
         int exp_r, exp_op;
         if (ins[15:12] == 4'd9) ins[15:12] = 4'd15;
         exp_r = operand(ins);
         exp_op = ins[15:12] <= 4'd6 ? int'(ins[15:12]) : 6;
         exec_instr(ins);
         n_chk++; if (mid_r !== 8'(exp_r) || mid_op !== 4'(exp_op)) $display("FAIL rnd_drive %h got %h/%h exp %h/%h", ins, mid_r, mid_op, exp_r, exp_op); else n_ok++;
         n_chk++; if (OUT_ACC !== 8'(m_acc) || OUT_CY !== 1'(m_cy) || OUT_ERR !== 1'(m_err)) $display("FAIL rnd_state %h got %h/%b/%b exp %h/%0d/%0d", ins, OUT_ACC, OUT_CY, OUT_ERR, m_acc, m_cy, m_err); else n_ok++;
`ifdef ALU_ACC_ZERO_FLAG_EN
         n_chk++; if (OUT_Z !== 1'(m_z)) $display("FAIL rnd_z %h got %b exp %0d", ins, OUT_Z, m_z); else n_ok++;
`endif
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      exec_instr(16'h6800);
      IN_VALID = 1; IN_INSTR = 16'h0801;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         dones += int'(OUT_DONE);
      end
      IN_VALID = 0;
      for (int i = 0; i < 10; i++) model_step(16'h0801);
      n_chk++; if (OUT_ACC !== 8'(m_acc) || m_acc != 10) $display("FAIL b2b_acc got %h exp 0a", OUT_ACC); else n_ok++;
      n_chk++; if (dones != 10) $display("FAIL b2b_done got %0d exp 10", dones); else n_ok++;
   endtask

   task automatic test_halt();
      exec_instr(16'h6842);
      exec_instr(16'h9000);
      n_chk++; if ({OUT_DONE, OUT_HALT, OUT_READY} !== 3'b110) $display("FAIL halt_enter got %b exp 110", {OUT_DONE, OUT_HALT, OUT_READY}); else n_ok++;
      IN_VALID = 1; IN_INSTR = 16'h68FF;
      repeat (6) @(posedge CLK);
      #1;
      n_chk++; if ({OUT_HALT, OUT_READY, OUT_DONE} !== 3'b100 || OUT_ACC !== 8'h42) $display("FAIL halt_hold got %b/%h exp 100/42", {OUT_HALT, OUT_READY, OUT_DONE}, OUT_ACC); else n_ok++;
      do_reset();
      n_chk++; if ({OUT_HALT, OUT_READY} !== 2'b01 || OUT_ACC !== 8'h00) $display("FAIL halt_exit got %b/%h exp 01/00", {OUT_HALT, OUT_READY}, OUT_ACC); else n_ok++;
   endtask

   task automatic test_reset_mid();
      exec_instr(16'h6800);
      IN_VALID = 1; IN_INSTR = 16'h1801;
      @(posedge CLK); #1;
      IN_VALID = 0; RST = 1;
      @(posedge CLK); #1;
      RST = 0;
      model_reset();
      n_chk++; if (OUT_ACC !== 8'h00 || OUT_CY !== 1'b0) $display("FAIL mid_rst got %h/%b exp 00/0", OUT_ACC, OUT_CY); else n_ok++;
      n_chk++; if ({OUT_DONE, OUT_READY} !== 2'b01) $display("FAIL mid_rst_hs got %b exp 01", {OUT_DONE, OUT_READY}); else n_ok++;
`ifdef ALU_ACC_ZERO_FLAG_EN
      exec_instr(16'h1800);
      n_chk++; if (OUT_Z !== 1'b1 || OUT_ACC !== 8'h00) $display("FAIL z_sub got %b/%h exp 1/00", OUT_Z, OUT_ACC); else n_ok++;
      exec_instr(16'h7000);
      n_chk++; if (OUT_Z !== 1'b1) $display("FAIL z_st got %b exp 1", OUT_Z); else n_ok++;
`endif
   endtask

   initial begin
      test_reset();
      test_ld();
      test_add_carry();
      test_st_or();
      test_illegal();
      test_random();
      test_back_to_back();
      test_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_acc_ctrl.md
Name: alu_acc_ctrl

Overview:
- Upstream control and state stage for the 8-bit ALU: accepts encoded instructions over a valid/ready handshake and holds the accumulator, carry flag and a small register file.
- Drives the ALU's operand/op/carry inputs and writes the ALU result and carry back into its own state.
- The ALU stays a separate combinational instance, wired beside this block at the next level up.

Parameters:
- NREG, 8, number of 8-bit general registers; power of two, 2..8. Index width IDX_W = $clog2(NREG) is a localparam.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- IN_INSTR  input  16  instruction word: [15:12] op, [11] imm flag, [10:8] reg index (low IDX_W bits used), [7:0] immediate
- IN_VALID  input  1  IN_INSTR valid
- OUT_READY  output  1  block can accept an instruction this cycle
- OUT_ALU_A  output  8  to ALU IN_A (accumulator)
- OUT_ALU_R  output  8  to ALU IN_R (operand)
- OUT_ALU_OP  output  4  to ALU IN_OP
- OUT_ALU_CY  output  1  to ALU CY_F (carry flag)
- IN_ALU_A  input  8  from ALU OUT_A
- IN_ALU_CY  input  1  from ALU OUT_CY
- OUT_ACC  output  8  accumulator value (observation)
- OUT_CY  output  1  carry flag
- OUT_DONE  output  1  one-cycle pulse when an instruction retires
- OUT_HALT  output  1  high while in HALT
- OUT_ERR  output  1  sticky illegal-opcode flag

Behaviour:
- Handshake: transfer occurs on a rising edge with IN_VALID && OUT_READY. OUT_READY = (state == IDLE). IN_INSTR is ignored when not ready.
- FSM has three states: IDLE, EXEC, HALT.
  - IDLE -> EXEC on transfer; IN_INSTR is latched into IR.
  - EXEC -> IDLE after one cycle, or -> HALT if IR.op == HALT.
  - HALT is left only by reset.
- Latency: transfer at edge t; the result is committed at edge t+1. OUT_DONE is high in the cycle after edge t+1, when the block is ready again. Throughput is 1 instruction per 2 cycles.
- ALU drive (all states, combinational from state regs):
  - OUT_ALU_A = ACC
  - OUT_ALU_R = IR.imm ? IR[7:0] : R[IR.idx]
  - OUT_ALU_OP = IR.op for ALU ops, else 4'b0110 (LD, harmless)
  - OUT_ALU_CY = CY
- Opcodes:
  - 0-6 (ADD, SUB, OR, AND, XOR, NOT, LD): at the commit edge, ACC <= IN_ALU_A and CY <= IN_ALU_CY. Carry is always taken from the ALU, so logic ops and LD clear CY.
  - 7 ST: R[IR.idx] <= ACC; ACC and CY unchanged.
  - 8 CLC: CY <= 0.
  - 9 HALT: no state change; OUT_DONE pulses and the FSM enters HALT.
  - 15 NOP: no change.
  - 10-14 illegal: executed as NOP, OUT_ERR <= 1 (sticky until reset).
- ST with the imm flag set: the flag is ignored.
- Reset (any state, including mid-EXEC) clears the in-flight instruction with no commit. Reset values:
  - FSM = IDLE, IR = 16'h0, ACC = 0, CY = 0, all R = 0
  - OUT_READY = 1 after reset (state IDLE), OUT_DONE = 0, OUT_HALT = 0, OUT_ERR = 0
  - ALU outputs follow from the cleared state.
- IN_VALID held high continuously: an instruction is accepted every other cycle and no instruction is duplicated.

Optional Feature:
- Macro ALU_ACC_ZERO_FLAG_EN.
- Defined: adds output port OUT_Z (1 bit, reset 0). OUT_Z is updated only at ALU-op commits, to (IN_ALU_A == 0); it is unchanged by ST, CLC, NOP, HALT and illegal ops.
- Undefined: no OUT_Z port and no Z register; all other behaviour identical.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit OP_CODE enum, extended with ST = 7, CLC = 8, HALT = 9, NOP = 15
  - instruction field position constants
  - FSM state enum {IDLE, EXEC, HALT}
- The ALU module adopts the same package enum so op encodings live in one place.
- One natural sub-module: alu_acc_regfile (NREG x 8 bits, one write port, one async read port, synchronous reset to 0).

Test Plan:
- Reset then LD imm 0x3C (16'h683C) -> after commit ACC = 0x3C, CY = 0, OUT_DONE pulses once, 2 cycles after acceptance.
- ACC = 0xF0, CY = 0; ADD imm 0x20 -> ACC = 0x10, CY = 1; next ADD imm 0x00 -> ACC = 0x11, CY = 0 (carry-in consumed).
- ACC = 0x05 after LD imm; ST R3; LD imm 0; OR R3 (reg operand, imm = 0) -> ACC = 0x05, R3 = 0x05, CY = 0.
- Opcode 12 with IN_VALID -> ACC/CY unchanged, OUT_ERR = 1 and stays 1 across later legal ops until RST.
- HALT (16'h9000) followed by IN_VALID held high with LD imm 0xFF -> OUT_HALT = 1, OUT_READY = 0, ACC unchanged; RST -> IDLE, OUT_READY = 1, ACC = 0.
- RST asserted in the EXEC cycle of SUB imm 0x01 from ACC = 0x00 -> no commit, ACC = 0, CY = 0 post-reset. With ALU_ACC_ZERO_FLAG_EN defined, SUB imm 0x00 from ACC = 0x00 with CY = 0 -> OUT_Z = 1.
